// File: rtl/switch_code_decoder.sv
// -----------------------------------------------------------------------------
// switch_code_decoder
//
// Purpose:
//   Decodes a stream of 2-bit switch codes into a debounced switch state.
//   A legal code (IDLE/ON/OFF) only takes effect after FILTER_LEN consecutive
//   accepted beats carry that same code. The illegal code 2'h2 sends the
//   decoder straight to ERR, where it stays until err_clr is raised.
//
// Parameters:
//   FILTER_LEN  consecutive identical accepted codes needed to commit (1..7)
//   CNT_W       width of toggle_cnt
//
// Optional feature:
//   SWITCH_DEC_TOGGLE_CNT_EN  when defined, toggle_cnt counts ON<->OFF
//                             transitions and saturates at all-ones; when
//                             undefined, toggle_cnt is tied to zero.
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous, active-low reset
//   code_valid   a code beat is present
//   code         switch code: 0 IDLE, 1 ON, 3 OFF, 2 illegal
//   code_ready   decoder accepts a beat this cycle (low only in ERR)
//   err_clr      leave the ERR state (ignored elsewhere)
//   state        decoded state: 0 IDLE, 1 ON, 3 OFF, 2 ERR
//   state_valid  one-cycle pulse after every state change
//   out_num      state number: IDLE 0, ON 2, OFF 4, ERR 7
//   err          high while the state is ERR
//   toggle_cnt   saturating count of ON<->OFF transitions
// -----------------------------------------------------------------------------
module switch_code_decoder #(
    parameter int FILTER_LEN = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             code_valid,
    input  logic [1:0]       code,
    output logic             code_ready,
    input  logic             err_clr,
    output logic [1:0]       state,
    output logic             state_valid,
    output logic [2:0]       out_num,
    output logic             err,
    output logic [CNT_W-1:0] toggle_cnt
);

    // The state encoding matches the code encoding so a committed code can be
    // cast directly into a state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'h0,
        ST_ON   = 2'h1,
        ST_ERR  = 2'h2,
        ST_OFF  = 2'h3
    } state_t;

    localparam logic [2:0] FILTER_MAX = 3'(FILTER_LEN);

    state_t     cur_state;
    state_t     next_state;
    logic [1:0] candidate;
    logic [1:0] next_candidate;
    logic [2:0] match_cnt;
    logic [2:0] next_match;
    logic       accept;

    assign code_ready = (cur_state != ST_ERR);
    assign accept     = code_valid && code_ready;
    assign state      = cur_state;

    function automatic logic [2:0] state_num(input state_t s);
        case (s)
            ST_IDLE: state_num = 3'h0;
            ST_ON:   state_num = 3'h2;
            ST_OFF:  state_num = 3'h4;
            default: state_num = 3'h7;
        endcase
    endfunction

    // Next-state and filter logic. The match counter saturates at FILTER_LEN,
    // so repeated beats of an already committed code re-commit the same state,
    // which produces no change. A differing legal code restarts the run at 1,
    // which with FILTER_LEN=1 commits immediately.
    always_comb begin
        next_state     = cur_state;
        next_candidate = candidate;
        next_match     = match_cnt;
        if (cur_state == ST_ERR) begin
            if (err_clr) begin
                next_state     = ST_IDLE;
                next_candidate = 2'h0;
                next_match     = 3'd0;
            end
        end else if (accept) begin
            if (code == 2'h2) begin
                next_state = ST_ERR;
            end else begin
                if (code == candidate) begin
                    next_match = (match_cnt >= FILTER_MAX) ? FILTER_MAX : match_cnt + 3'd1;
                end else begin
                    next_candidate = code;
                    next_match     = 3'd1;
                end
                if (next_match == FILTER_MAX) begin
                    next_state = state_t'(code);
                end
            end
        end
    end

    // State register with registered outputs derived from the next state, so
    // the outputs line up with the edge that accepts the committing beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= ST_IDLE;
            candidate   <= 2'h0;
            match_cnt   <= 3'd0;
            state_valid <= 1'b0;
            out_num     <= 3'h0;
            err         <= 1'b0;
        end else begin
            cur_state   <= next_state;
            candidate   <= next_candidate;
            match_cnt   <= next_match;
            state_valid <= (next_state != cur_state);
            out_num     <= state_num(next_state);
            err         <= (next_state == ST_ERR);
        end
    end

`ifdef SWITCH_DEC_TOGGLE_CNT_EN
    logic is_toggle;

    // Only direct ON<->OFF moves count; paths through IDLE or ERR do not.
    assign is_toggle = ((cur_state == ST_ON)  && (next_state == ST_OFF)) ||
                       ((cur_state == ST_OFF) && (next_state == ST_ON));

    always_ff @(posedge clk) begin
        if (!rst) begin
            toggle_cnt <= '0;
        end else if (is_toggle && (toggle_cnt != {CNT_W{1'b1}})) begin
            toggle_cnt <= toggle_cnt + 1'b1;
        end
    end
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_code_decoder.sv
// -----------------------------------------------------------------------------
// tb_switch_code_decoder
//
// Purpose:
//   Directed self-checking bench for switch_code_decoder. The main instance
//   uses FILTER_LEN=2 and CNT_W=2 so toggle_cnt saturation is reachable; a
//   second instance uses FILTER_LEN=1 to exercise immediate commits.
//   Expected toggle counts follow SWITCH_DEC_TOGGLE_CNT_EN (zero when the
//   macro is undefined).
// -----------------------------------------------------------------------------
module tb_switch_code_decoder;

`ifdef SWITCH_DEC_TOGGLE_CNT_EN
    localparam int TOG_EN = 1;
`else
    localparam int TOG_EN = 0;
`endif

    logic       clk;
    logic       rst;

    logic       code_valid;
    logic [1:0] code;
    logic       err_clr;
    logic       code_ready;
    logic [1:0] state;
    logic       state_valid;
    logic [2:0] out_num;
    logic       err;
    logic [1:0] toggle_cnt;

    logic       code_valid1;
    logic [1:0] code1;
    logic       err_clr1;
    logic       code_ready1;
    logic [1:0] state1;
    logic       state_valid1;
    logic [2:0] out_num1;
    logic       err1;
    logic [7:0] toggle_cnt1;

    int tests_run;
    int tests_failed;
    int pulses;

    switch_code_decoder #(.FILTER_LEN(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .code_ready(code_ready), .err_clr(err_clr), .state(state),
        .state_valid(state_valid), .out_num(out_num), .err(err),
        .toggle_cnt(toggle_cnt)
    );

    switch_code_decoder #(.FILTER_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .code_valid(code_valid1), .code(code1),
        .code_ready(code_ready1), .err_clr(err_clr1), .state(state1),
        .state_valid(state_valid1), .out_num(out_num1), .err(err1),
        .toggle_cnt(toggle_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int togExp(input int n);
        togExp = (TOG_EN != 0) ? n : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle on the selected instance (0 = main, 1 = FILTER_LEN=1),
    // then return the inputs to idle shortly after the edge.
    task automatic applyStimulus(input bit sel, input logic v, input logic [1:0] c, input logic clr);
        if (sel == 1'b0) begin
            code_valid = v; code = c; err_clr = clr;
        end else begin
            code_valid1 = v; code1 = c; err_clr1 = clr;
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0; code = 2'h0; err_clr = 1'b0;
        code_valid1 = 1'b0; code1 = 2'h0; err_clr1 = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; pulses = 0;
        rst = 1'b0;
        code_valid = 1'b0; code = 2'h0; err_clr = 1'b0;
        code_valid1 = 1'b0; code1 = 2'h0; err_clr1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset values
        checkOutput("rst_state", 32'(state), 32'h0);
        checkOutput("rst_out_num", 32'(out_num), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_state_valid", 32'(state_valid), 32'h0);
        checkOutput("rst_toggle", 32'(toggle_cnt), 32'h0);
        checkOutput("rst_ready", 32'(code_ready), 32'h1);

        // Codes 1,1 commit ON on the second beat
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("on1_state", 32'(state), 32'h0);
        checkOutput("on1_sv", 32'(state_valid), 32'h0);
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("on2_state", 32'(state), 32'h1);
        checkOutput("on2_out_num", 32'(out_num), 32'h2);
        checkOutput("on2_sv", 32'(state_valid), 32'h1);
        checkOutput("on2_toggle", 32'(toggle_cnt), 32'h0);
        applyStimulus(0, 0, 2'h0, 0);
        checkOutput("on_sv_drop", 32'(state_valid), 32'h0);
        checkOutput("on_hold", 32'(state), 32'h1);

        // 3,1,3,<gap>,3 commits OFF only on the final beat
        applyStimulus(0, 1, 2'h3, 0); pulses += int'(state_valid);
        applyStimulus(0, 1, 2'h1, 0); pulses += int'(state_valid);
        applyStimulus(0, 1, 2'h3, 0); pulses += int'(state_valid);
        checkOutput("off_pre_state", 32'(state), 32'h1);
        applyStimulus(0, 0, 2'h3, 0); pulses += int'(state_valid);
        applyStimulus(0, 1, 2'h3, 0); pulses += int'(state_valid);
        checkOutput("off_state", 32'(state), 32'h3);
        checkOutput("off_out_num", 32'(out_num), 32'h4);
        checkOutput("off_toggle", 32'(toggle_cnt), 32'(togExp(1)));
        applyStimulus(0, 0, 2'h0, 0); pulses += int'(state_valid);
        checkOutput("off_pulses", 32'(pulses), 32'h1);

        // Illegal code goes straight to ERR
        applyStimulus(0, 1, 2'h2, 0);
        checkOutput("err_state", 32'(state), 32'h2);
        checkOutput("err_flag", 32'(err), 32'h1);
        checkOutput("err_out_num", 32'(out_num), 32'h7);
        checkOutput("err_ready", 32'(code_ready), 32'h0);
        checkOutput("err_sv", 32'(state_valid), 32'h1);
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("err_hold", 32'(state), 32'h2);
        checkOutput("err_hold_sv", 32'(state_valid), 32'h0);
        applyStimulus(0, 0, 2'h0, 1);
        checkOutput("clr_state", 32'(state), 32'h0);
        checkOutput("clr_out_num", 32'(out_num), 32'h0);
        checkOutput("clr_err", 32'(err), 32'h0);
        checkOutput("clr_ready", 32'(code_ready), 32'h1);
        checkOutput("clr_sv", 32'(state_valid), 32'h1);
        // Candidate was OFF with a full run; a single 3 must not commit now
        applyStimulus(0, 1, 2'h3, 0);
        checkOutput("clr_filter", 32'(state), 32'h0);
        applyStimulus(0, 1, 2'h3, 0);
        checkOutput("idle_to_off", 32'(state), 32'h3);
        checkOutput("idle_to_off_tog", 32'(toggle_cnt), 32'(togExp(1)));
        applyStimulus(0, 0, 2'h0, 1);
        checkOutput("clr_ignored", 32'(state), 32'h3);
        checkOutput("clr_ignored_sv", 32'(state_valid), 32'h0);

        // Alternate ON/OFF five times; CNT_W=2 saturates at 3
        applyStimulus(0, 1, 2'h1, 0); applyStimulus(0, 1, 2'h1, 0);
        checkOutput("alt1_state", 32'(state), 32'h1);
        checkOutput("alt1_tog", 32'(toggle_cnt), 32'(togExp(2)));
        applyStimulus(0, 1, 2'h3, 0); applyStimulus(0, 1, 2'h3, 0);
        checkOutput("alt2_tog", 32'(toggle_cnt), 32'(togExp(3)));
        applyStimulus(0, 1, 2'h1, 0); applyStimulus(0, 1, 2'h1, 0);
        checkOutput("alt3_tog", 32'(toggle_cnt), 32'(togExp(3)));
        applyStimulus(0, 1, 2'h3, 0); applyStimulus(0, 1, 2'h3, 0);
        applyStimulus(0, 1, 2'h1, 0); applyStimulus(0, 1, 2'h1, 0);
        checkOutput("alt5_state", 32'(state), 32'h1);
        checkOutput("alt5_tog", 32'(toggle_cnt), 32'(togExp(3)));

        // Beat offered in the err_clr exit cycle is not accepted
        applyStimulus(0, 1, 2'h2, 0);
        checkOutput("err2_state", 32'(state), 32'h2);
        applyStimulus(0, 1, 2'h1, 1);
        checkOutput("exit_state", 32'(state), 32'h0);
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("exit_no_accept", 32'(state), 32'h0);
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("exit_then_on", 32'(state), 32'h1);
        checkOutput("idle_on_tog", 32'(toggle_cnt), 32'(togExp(3)));

        // Reset mid-run discards a partial run
        pulseReset();
        checkOutput("rst2_state", 32'(state), 32'h0);
        checkOutput("rst2_toggle", 32'(toggle_cnt), 32'h0);
        applyStimulus(0, 1, 2'h1, 0);
        pulseReset();
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("rst_restart", 32'(state), 32'h0);
        applyStimulus(0, 1, 2'h1, 0);
        checkOutput("rst_restart_on", 32'(state), 32'h1);

        // Reset from ERR
        applyStimulus(0, 1, 2'h2, 0);
        pulseReset();
        checkOutput("rst_err_state", 32'(state), 32'h0);
        checkOutput("rst_err_flag", 32'(err), 32'h0);
        checkOutput("rst_err_ready", 32'(code_ready), 32'h1);

        // FILTER_LEN=1: every accepted legal code commits
        applyStimulus(1, 1, 2'h1, 0);
        checkOutput("f1_on", 32'(state1), 32'h1);
        checkOutput("f1_on_sv", 32'(state_valid1), 32'h1);
        applyStimulus(1, 1, 2'h3, 0);
        checkOutput("f1_off", 32'(state1), 32'h3);
        checkOutput("f1_tog", 32'(toggle_cnt1), 32'(togExp(1)));
        applyStimulus(1, 1, 2'h3, 0);
        checkOutput("f1_same_sv", 32'(state_valid1), 32'h0);
        applyStimulus(1, 1, 2'h0, 0);
        checkOutput("f1_idle", 32'(state1), 32'h0);
        checkOutput("f1_idle_num", 32'(out_num1), 32'h0);
        checkOutput("f1_err_flag", 32'(err1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/switch_code_decoder.md
SWITCH_CODE_DECODER -- requirements
Module: switch_code_decoder

Interface
REQ-001 FILTER_LEN, default 2, number of consecutive identical accepted codes needed to commit; legal range 1..7.
REQ-002 CNT_W, default 8, width of toggle_cnt.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 code_valid  input  1  code beat present.
REQ-006 code  input  2  switch code: 2'h0 IDLE, 2'h1 ON, 2'h3 OFF, 2'h2 illegal.
REQ-007 code_ready  output  1  decoder accepts a beat this cycle.
REQ-008 err_clr  input  1  leave ERR state.
REQ-009 state  output  2  decoded state: 2'h0 IDLE, 2'h1 ON, 2'h3 OFF, 2'h2 ERR.
REQ-010 state_valid  output  1  one-cycle pulse on every state change.
REQ-011 out_num  output  3  state number: IDLE 3'h0, ON 3'h2, OFF 3'h4, ERR 3'h7.
REQ-012 err  output  1  high while state is ERR.
REQ-013 toggle_cnt  output  CNT_W  count of ON<->OFF transitions.

Function
REQ-014 A beat is accepted in a cycle only when code_valid and code_ready are both 1.
REQ-015 code_ready is 1 in IDLE, ON and OFF, and 0 in ERR.
REQ-016 Filter: candidate register plus match counter; an accepted legal code equal to the candidate increments the match counter, saturating at FILTER_LEN.
REQ-017 An accepted legal code that differs from the candidate loads it as the candidate and sets the match counter to 1.
REQ-018 A commit occurs on the accepted beat that brings the match counter to FILTER_LEN.
REQ-019 A commit of a code equal to the current state causes no state change.
REQ-020 With FILTER_LEN=1, every accepted legal code commits.
REQ-021 Latency: state, out_num, err and state_valid update on the clock edge that accepts the committing beat; the outputs are registered.
REQ-022 FSM transitions: IDLE/ON/OFF go to the committed code's state.
REQ-023 An accepted code 2'h2 moves the FSM to ERR on that edge, with no filtering, from any non-ERR state.
REQ-024 ERR holds until err_clr=1.
REQ-025 On leaving ERR, the next state is IDLE, the candidate is cleared to 2'h0 and the match counter is cleared to 0.
REQ-026 err_clr is ignored outside ERR.
REQ-027 No beat is accepted in the cycle err_clr exits ERR, because code_ready=0 in that cycle.
REQ-028 state_valid is 1 for exactly one cycle after each edge where state changes, and 0 otherwise.
REQ-029 toggle_cnt increments by 1 on each ON->OFF or OFF->ON transition.
REQ-030 toggle_cnt saturates at 2^CNT_W-1.
REQ-031 toggle_cnt is not changed by transitions through IDLE or ERR.
REQ-032 code_valid=0 leaves the filter state unchanged; gaps do not break a match run.

Reset
REQ-033 While rst=0 at a clock edge, the block loads reset values.
REQ-034 Reset values: state=IDLE, out_num=3'h0, err=0, state_valid=0, toggle_cnt=0, candidate=2'h0, match counter=0.
REQ-035 code_ready=1 in the first cycle after reset release.
REQ-036 Reset asserted mid-run discards any partial filter run, including from ERR.

Configuration
REQ-037 Macro SWITCH_DEC_TOGGLE_CNT_EN: when defined, toggle_cnt and its counter are implemented per REQ-029..031.
REQ-038 When SWITCH_DEC_TOGGLE_CNT_EN is undefined, toggle_cnt is tied to 0, no counter logic exists, and all other behaviour is identical.

Verification
REQ-039 FILTER_LEN=2, reset, accept codes 1,1 -> state=ON, out_num=2, state_valid pulse on second edge, toggle_cnt=0.
REQ-040 From ON, accept 3,1,3,3 -> state=OFF only after the final beat, toggle_cnt=1, and exactly one state_valid pulse.
REQ-041 From OFF, accept code 2 -> state=ERR, err=1, out_num=7, code_ready=0; then err_clr=1 -> IDLE, out_num=0, code_ready=1, filter cleared.
REQ-042 CNT_W=2, alternate committed ON/OFF 5 times -> toggle_cnt saturates at 3; with macro undefined -> toggle_cnt stays 0.
REQ-043 Accept one code 1, assert rst=0 for one cycle, then accept one code 1 -> state stays IDLE (run restarted); one further code 1 -> ON.
